pfw_np: RTL and testbench
=========================

# pfw_np

Parametrised N-port packet forwarding stage between the key extractor and the packet-action controller. For each packet it decides discard, unicast, broadcast or flood. It emits a port-bitmap action alongside a two-cycle-delayed copy of the packet. It generalises the two-port forwarder to PORT_NUM ports with an optional source-MAC learning table.

## Interface
- PORT_NUM, 4, number of ports (2..16); port indices 0..PORT_NUM-1
- PORT_W, 4, width of port index, ≥ clog2(PORT_NUM)
- CPU_PORT, 0, port index of the local CPU/LCM port
- LCM_SMID, 8'd128, SMID value (head word bits [95:88]) marking CPU-originated packets
- TBL_DEPTH, 8, learning-table entries (power of two, 2..32)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset (sampled on rising clk)
- in_pfw_data  in  134  packet word; [133:132] = 01 head, 11 body, 10 tail
- in_pfw_data_wr  in  1  word strobe
- in_pfw_valid  in  1  packet-valid flag
- in_pfw_valid_wr  in  1  packet-valid strobe, with tail
- in_pfw_pkttype  in  3  packet type, stable head..tail
- in_pfw_key  in  96+PORT_W  {dmac[47:0], smac[47:0], inport}, valid with head, stable to tail
- local_mac_addr  in  48  CPU MAC
- tbl_clr  in  1  one-cycle pulse: invalidate all table entries
- out_pfw_data  out  134  delayed packet word
- out_pfw_data_wr  out  1  word strobe
- out_pfw_valid  out  1  packet-valid flag, with tail
- out_pfw_valid_wr  out  1  packet-valid strobe
- out_pfw_action  out  5+PORT_NUM  {mode[1:0], pkttype[2:0], bitmap[PORT_NUM-1:0]}; mode 00 unicast, 10 broadcast, 01 flood
- out_pfw_action_wr  out  1  action strobe
- out_pfw_drop_cnt  out  32  discarded-packet count, saturating

## Operation
- Packet words are contiguous head..tail. Minimum length is 2 words. Inter-packet gap is ≥ 2 idle cycles; behaviour on violation is undefined.
- from_cpu = (head[95:88] == LCM_SMID).
- Decision is computed at head cycle T and registered; priority top-down:
  1. !from_cpu and smac == local_mac_addr (loop) -> discard.
  2. dmac == FF..FF -> mode 10, bitmap = all ports except source.
  3. dmac == local_mac_addr -> mode 00, bitmap = 1<<CPU_PORT.
  4. Table hit on dmac -> mode 00, bitmap = 1<<hit_port.
  5. Otherwise -> mode 01, bitmap = all except source.
- Source port = CPU_PORT if from_cpu, else inport.
- If the unicast bitmap equals the source port's bit, the packet is discarded (hairpin filter).
- Discard outputs nothing for the packet and increments out_pfw_drop_cnt, which saturates at FFFF_FFFF.
- States:
  - IDLE -> LOOK on head word.
  - LOOK -> FWD, or -> DISC.
  - FWD -> IDLE after the tail is output.
  - DISC -> IDLE on tail input.
- Learning uses table state from before this packet, so a packet never hits on its own smac.

## Timing
- Reset (rst_n low at rising clk): all outputs 0, drop count 0, state IDLE, delay registers 0, table entries invalid, replace pointer 0.
- Data latency is exactly 2 cycles: input word at cycle k appears on out_pfw_data with out_pfw_data_wr at k+2.
- out_pfw_action_wr is a one-cycle pulse coincident with the output head word.
- out_pfw_valid and out_pfw_valid_wr are asserted with the output tail word only. out_pfw_valid copies in_pfw_valid captured at the input tail.
- Table lookup and learning are compare-all, single-cycle. A learn write commits at T+1.
- tbl_clr in the same cycle as a learn: the clear wins, and the entry is not written.
- Reset mid-packet: outputs go to 0 the next cycle. The remainder of the packet is ignored until the next head in IDLE.

## Configuration
- PFW_LEARN_EN defined:
  - The learning table is built. Entry = {valid, mac[47:0], port[PORT_W-1:0]}.
  - On every non-discarded packet with !from_cpu and smac[40]==0 (unicast source):
    - If smac is present, its port is updated.
    - Otherwise it is written at the replace pointer, which increments and wraps TBL_DEPTH-1 -> 0.
- PFW_LEARN_EN undefined:
  - No table; rule 4 never hits.
  - tbl_clr is ignored.
  - Non-local unicast always floods.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with in_pfw_data_wr=1 -> all outputs 0, out_pfw_drop_cnt=0.
- Broadcast: 4-word packet, inport=2, dmac=FF..FF, PORT_NUM=4 -> out head at T+2; action = {10, pkttype, 4'b1011}; valid with tail at T+5.
- Unknown unicast: inport=1 -> action mode 01, bitmap 4'b1101.
  - With PFW_LEARN_EN, a reply from inport=3 to that smac -> mode 00, bitmap 4'b0010.
- Loop drop: smac=local_mac_addr, SMID=5 -> no output strobes, drop count 0->1.
- CPU packet: SMID=128, dmac=local_mac_addr -> hairpin discard, drop count +1.
- Replacement: learn TBL_DEPTH+1 distinct smacs -> the first MAC misses (floods), and the last MAC hits. tbl_clr pulse -> all MACs miss.

Source files
------------

// File: rtl/pfw_np.sv
// pfw_np: N-port forwarding decision stage with a two-cycle packet delay line.
// Define PFW_LEARN_EN to build the source-MAC learning table.
module pfw_np #(
    parameter int unsigned PORT_NUM  = 4,
    parameter int unsigned PORT_W    = 4,
    parameter int unsigned CPU_PORT  = 0,
    parameter logic [7:0]  LCM_SMID  = 8'd128,
    parameter int unsigned TBL_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [133:0]            in_pfw_data,
    input  logic                    in_pfw_data_wr,
    input  logic                    in_pfw_valid,
    input  logic                    in_pfw_valid_wr,
    input  logic [2:0]              in_pfw_pkttype,
    input  logic [96+PORT_W-1:0]    in_pfw_key,
    input  logic [47:0]             local_mac_addr,
    input  logic                    tbl_clr,
    output logic [133:0]            out_pfw_data,
    output logic                    out_pfw_data_wr,
    output logic                    out_pfw_valid,
    output logic                    out_pfw_valid_wr,
    output logic [5+PORT_NUM-1:0]   out_pfw_action,
    output logic                    out_pfw_action_wr,
    output logic [31:0]             out_pfw_drop_cnt
);
    localparam int unsigned KEY_W = 96 + PORT_W;
    localparam int unsigned ACT_W = 5 + PORT_NUM;
    localparam int unsigned IDX_W = (TBL_DEPTH > 1) ? $clog2(TBL_DEPTH) : 1;
    localparam logic [PORT_NUM-1:0] BM_ONE = {{(PORT_NUM-1){1'b0}}, 1'b1};
    localparam logic [PORT_NUM-1:0] BM_ALL = {PORT_NUM{1'b1}};
    localparam logic [PORT_NUM-1:0] BM_CPU = BM_ONE << CPU_PORT;

    typedef enum logic [1:0] {IDLE, LOOK, FWD, DISC} state_t;

    state_t state, state_nxt;

    logic [47:0]         dmac, smac;
    logic [PORT_W-1:0]   inport, src_port_c;
    logic [PORT_NUM-1:0] src_bit_c, bm_c;
    logic [1:0]          mode_c;
    logic                head_c, tail_in_c, from_cpu_c, disc_c;
    logic                dhit_c;
    logic [PORT_W-1:0]   dhit_port_c;

    logic                dec_disc;
    logic [ACT_W-1:0]    dec_action;

    logic [133:0]        s1_data;
    logic                s1_wr, s1_valid, s1_tail_c;
    logic                fwd_out_c, act_pulse_c, drop_inc_c;

    assign dmac       = in_pfw_key[KEY_W-1 -: 48];
    assign smac       = in_pfw_key[PORT_W +: 48];
    assign inport     = in_pfw_key[PORT_W-1:0];
    assign head_c     = in_pfw_data_wr && (in_pfw_data[133:132] == 2'b01);
    assign tail_in_c  = in_pfw_data_wr && (in_pfw_data[133:132] == 2'b10);
    assign from_cpu_c = (in_pfw_data[95:88] == LCM_SMID);
    assign src_port_c = from_cpu_c ? PORT_W'(CPU_PORT) : inport;
    assign src_bit_c  = BM_ONE << src_port_c;
    assign s1_tail_c  = (s1_data[133:132] == 2'b10);

`ifdef PFW_LEARN_EN
    logic [TBL_DEPTH-1:0] tbl_vld;
    logic [47:0]          tbl_mac  [TBL_DEPTH];
    logic [PORT_W-1:0]    tbl_port [TBL_DEPTH];
    logic [IDX_W-1:0]     rep_ptr;
    logic                 shit_c, learn_c;
    logic [IDX_W-1:0]     shit_idx_c;

    // Compare-all lookup of dmac (forwarding) and smac (learning refresh)
    always_comb begin
        dhit_c      = 1'b0;
        dhit_port_c = '0;
        shit_c      = 1'b0;
        shit_idx_c  = '0;
        for (int i = 0; i < TBL_DEPTH; i++) begin
            if (tbl_vld[i] && (tbl_mac[i] == dmac)) begin
                dhit_c      = 1'b1;
                dhit_port_c = tbl_port[i];
            end
            if (tbl_vld[i] && (tbl_mac[i] == smac)) begin
                shit_c     = 1'b1;
                shit_idx_c = IDX_W'(i);
            end
        end
    end

    assign learn_c = (state == IDLE) && head_c && !disc_c && !from_cpu_c && !smac[40];

    // Table write; a clear pulse overrides a coincident learn
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tbl_vld <= '0;
            rep_ptr <= '0;
            for (int i = 0; i < TBL_DEPTH; i++) begin
                tbl_mac[i]  <= '0;
                tbl_port[i] <= '0;
            end
        end else if (tbl_clr) begin
            tbl_vld <= '0;
        end else if (learn_c) begin
            if (shit_c) begin
                tbl_port[shit_idx_c] <= inport;
            end else begin
                tbl_vld[rep_ptr]  <= 1'b1;
                tbl_mac[rep_ptr]  <= smac;
                tbl_port[rep_ptr] <= inport;
                rep_ptr           <= rep_ptr + IDX_W'(1);
            end
        end
    end
`else
    logic unused_c;
    assign unused_c    = ^{tbl_clr, IDX_W'(1)};
    assign dhit_c      = 1'b0;
    assign dhit_port_c = '0;
`endif

    // Forwarding decision for the head word, in priority order
    always_comb begin
        disc_c = 1'b0;
        mode_c = 2'b01;
        bm_c   = BM_ALL & ~src_bit_c;
        if (!from_cpu_c && (smac == local_mac_addr)) begin
            disc_c = 1'b1;
        end else if (&dmac) begin
            mode_c = 2'b10;
            bm_c   = BM_ALL & ~src_bit_c;
        end else if (dmac == local_mac_addr) begin
            mode_c = 2'b00;
            bm_c   = BM_CPU;
        end else if (dhit_c) begin
            mode_c = 2'b00;
            bm_c   = BM_ONE << dhit_port_c;
        end
        if ((mode_c == 2'b00) && (bm_c == src_bit_c)) begin
            disc_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A discarded two-word packet has its tail already in LOOK, so it returns to IDLE directly
    always_comb begin
        state_nxt   = state;
        fwd_out_c   = 1'b0;
        act_pulse_c = 1'b0;
        drop_inc_c  = 1'b0;
        case (state)
            IDLE: if (head_c) state_nxt = LOOK;
            LOOK: begin
                if (!dec_disc) begin
                    state_nxt   = FWD;
                    fwd_out_c   = 1'b1;
                    act_pulse_c = 1'b1;
                end else begin
                    drop_inc_c = 1'b1;
                    state_nxt  = tail_in_c ? IDLE : DISC;
                end
            end
            FWD: begin
                fwd_out_c = 1'b1;
                if (s1_wr && s1_tail_c) state_nxt = IDLE;
            end
            DISC: if (tail_in_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decision capture, delay line and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_disc          <= 1'b0;
            dec_action        <= '0;
            s1_data           <= '0;
            s1_wr             <= 1'b0;
            s1_valid          <= 1'b0;
            out_pfw_data      <= '0;
            out_pfw_data_wr   <= 1'b0;
            out_pfw_valid     <= 1'b0;
            out_pfw_valid_wr  <= 1'b0;
            out_pfw_action    <= '0;
            out_pfw_action_wr <= 1'b0;
            out_pfw_drop_cnt  <= '0;
        end else begin
            if ((state == IDLE) && head_c) begin
                dec_disc   <= disc_c;
                dec_action <= {mode_c, in_pfw_pkttype, bm_c};
            end
            s1_data           <= in_pfw_data;
            s1_wr             <= in_pfw_data_wr;
            s1_valid          <= in_pfw_valid_wr & in_pfw_valid;
            out_pfw_data      <= (fwd_out_c && s1_wr) ? s1_data : '0;
            out_pfw_data_wr   <= fwd_out_c && s1_wr;
            out_pfw_valid_wr  <= fwd_out_c && s1_wr && s1_tail_c;
            out_pfw_valid     <= fwd_out_c && s1_wr && s1_tail_c && s1_valid;
            out_pfw_action_wr <= act_pulse_c;
            if (act_pulse_c) out_pfw_action <= dec_action;
            if (drop_inc_c && (out_pfw_drop_cnt != 32'hFFFF_FFFF)) begin
                out_pfw_drop_cnt <= out_pfw_drop_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pfw_np.sv
// tb_pfw_np: directed scoreboard bench for pfw_np (PORT_NUM=4, CPU_PORT=0).
module tb_pfw_np;
    localparam int unsigned PN = 4;
    localparam int unsigned PW = 4;
    localparam int unsigned TD = 8;
    localparam logic [47:0] LMAC = 48'h0011_2233_4455;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [133:0]  in_pfw_data;
    logic          in_pfw_data_wr;
    logic          in_pfw_valid;
    logic          in_pfw_valid_wr;
    logic [2:0]    in_pfw_pkttype;
    logic [99:0]   in_pfw_key;
    logic [47:0]   local_mac_addr;
    logic          tbl_clr;
    logic [133:0]  out_pfw_data;
    logic          out_pfw_data_wr;
    logic          out_pfw_valid;
    logic          out_pfw_valid_wr;
    logic [8:0]    out_pfw_action;
    logic          out_pfw_action_wr;
    logic [31:0]   out_pfw_drop_cnt;

    always #5 clk = ~clk;

    pfw_np #(.PORT_NUM(PN), .PORT_W(PW), .CPU_PORT(0), .LCM_SMID(8'd128), .TBL_DEPTH(TD)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_pfw_data(in_pfw_data), .in_pfw_data_wr(in_pfw_data_wr),
        .in_pfw_valid(in_pfw_valid), .in_pfw_valid_wr(in_pfw_valid_wr),
        .in_pfw_pkttype(in_pfw_pkttype), .in_pfw_key(in_pfw_key),
        .local_mac_addr(local_mac_addr), .tbl_clr(tbl_clr),
        .out_pfw_data(out_pfw_data), .out_pfw_data_wr(out_pfw_data_wr),
        .out_pfw_valid(out_pfw_valid), .out_pfw_valid_wr(out_pfw_valid_wr),
        .out_pfw_action(out_pfw_action), .out_pfw_action_wr(out_pfw_action_wr),
        .out_pfw_drop_cnt(out_pfw_drop_cnt)
    );

    typedef struct {
        logic [133:0] data;
        logic         head;
        logic [8:0]   action;
        logic         tail;
        logic         valid;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   m_drop = 0;
    logic [47:0]   m_mac  [TD];
    logic [PW-1:0] m_port [TD];
    logic [TD-1:0] m_vld = '0;
    int            m_ptr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on every output word
    always @(negedge clk) begin
        if (mon_en) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                check("missing_word", 134'(sbq.size()), 134'(0));
                void'(sbq.pop_front());
            end
            if (out_pfw_data_wr) begin
                if (sbq.size() == 0) begin
                    check("spurious_word", 134'(out_pfw_data_wr), 134'(0));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("out_data", out_pfw_data, e.data);
                    check("out_cycle", 134'(cyc), 134'(e.cyc));
                    check("action_wr", 134'(out_pfw_action_wr), 134'(e.head));
                    if (e.head) check("action", 134'(out_pfw_action), 134'(e.action));
                    check("valid_wr", 134'(out_pfw_valid_wr), 134'(e.tail));
                    if (e.tail) check("valid", 134'(out_pfw_valid), 134'(e.valid));
                end
            end else if (out_pfw_action_wr || out_pfw_valid_wr) begin
                check("stray_strobe", 134'({out_pfw_action_wr, out_pfw_valid_wr}), 134'(0));
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_pfw_data_wr  = 1'b0;
            in_pfw_valid_wr = 1'b0;
            in_pfw_valid    = 1'b0;
            in_pfw_data     = '0;
        end
    endtask

    function automatic logic [133:0] mk_word(input int i, input int n, input logic [7:0] smid);
        logic [133:0] w;
        w = 134'({$urandom, $urandom, $urandom, $urandom, $urandom});
        w[133:132] = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
        if (i == 0) w[95:88] = smid;
        return w;
    endfunction

    // Reference decision from the forwarding rules, then drive the packet
    task automatic send_pkt(input int n, input logic [7:0] smid, input logic [47:0] dmac,
                            input logic [47:0] smac, input logic [PW-1:0] inport,
                            input logic [2:0] pt, input logic vld);
        logic          fc, disc;
        logic [1:0]    mode;
        logic [PN-1:0] one, srcb, bm;
        int            src;
        exp_t          e;
        logic [133:0]  w;
        bit            hit, shit;
        int            hport, sidx;
        one  = 1;
        fc   = (smid == 8'd128);
        src  = fc ? 0 : int'(inport);
        srcb = one << src;
        hit = 0; shit = 0; hport = 0; sidx = 0;
`ifdef PFW_LEARN_EN
        for (int k = 0; k < TD; k++) begin
            if (m_vld[k] && m_mac[k] == dmac) begin hit = 1; hport = int'(m_port[k]); end
            if (m_vld[k] && m_mac[k] == smac) begin shit = 1; sidx = k; end
        end
`endif
        disc = 0; mode = 2'b01; bm = ~srcb;
        if (!fc && smac == LMAC) disc = 1;
        else if (dmac == BCAST) begin mode = 2'b10; bm = ~srcb; end
        else if (dmac == LMAC) begin mode = 2'b00; bm = one; end
        else if (hit) begin mode = 2'b00; bm = one << hport; end
        if (mode == 2'b00 && bm == srcb) disc = 1;
        if (disc) m_drop++;
`ifdef PFW_LEARN_EN
        if (!disc && !fc && !smac[40]) begin
            if (shit) m_port[sidx] = inport;
            else begin
                m_vld[m_ptr] = 1'b1; m_mac[m_ptr] = smac; m_port[m_ptr] = inport;
                m_ptr = (m_ptr + 1) % TD;
            end
        end
`endif
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            w = mk_word(i, n, smid);
            in_pfw_data     = w;
            in_pfw_data_wr  = 1'b1;
            in_pfw_pkttype  = pt;
            in_pfw_key      = {dmac, smac, inport};
            in_pfw_valid_wr = (i == n - 1);
            in_pfw_valid    = (i == n - 1) ? vld : 1'b0;
            if (!disc) begin
                e.data = w; e.head = (i == 0); e.action = {mode, pt, bm};
                e.tail = (i == n - 1); e.valid = vld; e.cyc = cyc + 2;
                sbq.push_back(e);
            end
        end
        idle(4);
        check("drop_cnt", 134'(out_pfw_drop_cnt), 134'(m_drop));
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        tbl_clr = 1'b1;
        @(posedge clk); #1;
        tbl_clr = 1'b0;
        m_vld = '0;
    endtask

    initial begin
        logic [47:0] mac_a, mac_b, qsmac;
        logic [133:0] w;
        mac_a = 48'h0A00_0000_00A1;
        mac_b = 48'h0B00_0000_00B2;
        qsmac = 48'h0100_0000_00CC;
        rst_n = 1'b0; tbl_clr = 1'b0; local_mac_addr = LMAC;
        in_pfw_pkttype = 3'd0; in_pfw_key = '0; in_pfw_valid = 1'b0; in_pfw_valid_wr = 1'b0;
        in_pfw_data = mk_word(0, 4, 8'd5); in_pfw_data_wr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data", out_pfw_data, '0);
        check("rst_strobes", 134'({out_pfw_data_wr, out_pfw_valid, out_pfw_valid_wr, out_pfw_action_wr}), 134'(0));
        check("rst_action", 134'(out_pfw_action), 134'(0));
        check("rst_drop", 134'(out_pfw_drop_cnt), 134'(0));
        in_pfw_data_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        idle(2);

        send_pkt(4, 8'd5, BCAST, mac_a, 4'd2, 3'd3, 1'b1);          // broadcast
        send_pkt(3, 8'd5, 48'h0C00_0000_0001, mac_b, 4'd1, 3'd1, 1'b1); // unknown unicast, learn B@1
        send_pkt(3, 8'd5, mac_b, mac_a, 4'd3, 3'd2, 1'b0);          // reply to B
        send_pkt(3, 8'd5, 48'h0C00_0000_0002, LMAC, 4'd2, 3'd0, 1'b1);  // loop drop
        send_pkt(3, 8'd128, LMAC, 48'h0D00_0000_0001, 4'd2, 3'd4, 1'b1); // CPU hairpin drop
        send_pkt(2, 8'd5, LMAC, 48'h0E00_0000_0001, 4'd2, 3'd5, 1'b1);   // to CPU, min length
        send_pkt(2, 8'd5, mac_b, 48'h0E00_0000_0002, 4'd1, 3'd6, 1'b1);  // hairpin on learned port
        send_pkt(5, 8'd128, 48'h0C00_0000_0003, 48'h0E00_0000_0003, 4'd2, 3'd7, 1'b1); // CPU flood

        for (int i = 0; i <= TD; i++) begin
            send_pkt(2, 8'd5, 48'h0C00_0000_0010, 48'h0200_0000_0100 + 48'(i), 4'd2, 3'd1, 1'b1);
        end
        send_pkt(2, 8'd5, 48'h0200_0000_0100, qsmac, 4'd3, 3'd2, 1'b1);
        send_pkt(2, 8'd5, 48'h0200_0000_0100 + 48'(TD), qsmac, 4'd3, 3'd2, 1'b1);
        pulse_clr();
        send_pkt(2, 8'd5, 48'h0200_0000_0100 + 48'(TD), qsmac, 4'd3, 3'd2, 1'b1);
        send_pkt(2, 8'd5, mac_b, qsmac, 4'd3, 3'd2, 1'b1);

        // Reset mid-packet: only the head word escapes, the rest is dropped silently
        @(posedge clk); #1;
        w = mk_word(0, 4, 8'd5);
        in_pfw_data = w; in_pfw_data_wr = 1'b1; in_pfw_key = {BCAST, qsmac, 4'd1};
        in_pfw_pkttype = 3'd2;
        sbq.push_back('{data: w, head: 1'b1, action: {2'b10, 3'd2, 4'b1101}, tail: 1'b0, valid: 1'b0, cyc: cyc + 2});
        @(posedge clk); #1;
        in_pfw_data = mk_word(1, 4, 8'd5);
        @(posedge clk); #1;
        in_pfw_data = mk_word(2, 4, 8'd5); rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_pfw_data = mk_word(3, 4, 8'd5); in_pfw_valid_wr = 1'b1; in_pfw_valid = 1'b1;
        m_drop = 0; m_vld = '0; m_ptr = 0;
        @(negedge clk);
        check("midrst_data_wr", 134'(out_pfw_data_wr), 134'(0));
        idle(4);
        check("midrst_drop", 134'(out_pfw_drop_cnt), 134'(0));
        send_pkt(3, 8'd5, BCAST, qsmac, 4'd0, 3'd1, 1'b1);
        send_pkt(2, 8'd5, mac_b, qsmac, 4'd2, 3'd3, 1'b0);

        idle(4);
        check("sb_empty", 134'(sbq.size()), 134'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
